// File: rtl/fetch_sequencer_pkg.sv
// Shared definitions for the instruction-fetch sequencer: FSM state encoding,
// the word placed on Instruction when the output stage is flushed, and the
// program-counter increment.
package fetch_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2,
        ST_FAULT  = 2'd3
    } fetch_state_e;

    localparam logic [31:0] NOP_WORD = 32'h0000_0000;
    localparam int          PC_INC   = 4;

endpackage

// File: rtl/fetch_sequencer_if.sv
// Bundles the instruction-memory read port and the IF/ID valid/ready
// handshake. The sequencer is the master; memory and IF/ID sit on the slave side.
interface fetch_sequencer_if #(
    parameter int ADDR_W = 32
);
    logic [ADDR_W-1:0] ImemAddress;
    logic [31:0]       ImemInstruction;
    logic              InstrValid;
    logic              InstrReady;
    logic [31:0]       Instruction;
    logic [ADDR_W-1:0] InstrPC;
    logic [ADDR_W-1:0] PCPlus4;

    modport master (
        output ImemAddress,
        input  ImemInstruction,
        output InstrValid,
        input  InstrReady,
        output Instruction,
        output InstrPC,
        output PCPlus4
    );

    modport slave (
        input  ImemAddress,
        output ImemInstruction,
        input  InstrValid,
        output InstrReady,
        input  Instruction,
        input  InstrPC,
        input  PCPlus4
    );
endinterface

// File: rtl/fetch_sequencer_out_stage.sv
// Single-entry valid/ready output register. It holds the fetched word together
// with its PC and PC+4. A flush drops the held word. A load captures a new one.
// Otherwise the entry drains once the consumer accepts it.
module fetch_out_stage
    import fetch_sequencer_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              load,
    input  logic              ready,
    input  logic [31:0]       instr_in,
    input  logic [ADDR_W-1:0] pc_in,
    output logic              valid_o,
    output logic [31:0]       instr_o,
    output logic [ADDR_W-1:0] pc_o,
    output logic [ADDR_W-1:0] pc4_o
);

    logic              valid_q, valid_d;
    logic [31:0]       instr_q, instr_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] pc4_q, pc4_d;

    // Next-state of the entry: flush beats load, and load beats drain.
    always_comb begin
        valid_d = valid_q;
        instr_d = instr_q;
        pc_d    = pc_q;
        pc4_d   = pc4_q;
        if (flush) begin
            valid_d = 1'b0;
            instr_d = NOP_WORD;
        end else if (load) begin
            valid_d = 1'b1;
            instr_d = instr_in;
            pc_d    = pc_in;
            pc4_d   = pc_in + ADDR_W'(PC_INC);
        end else if (ready) begin
            valid_d = 1'b0;
        end
    end

    // Entry registers, cleared immediately on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            instr_q <= NOP_WORD;
            pc_q    <= '0;
            pc4_q   <= ADDR_W'(PC_INC);
        end else begin
            valid_q <= valid_d;
            instr_q <= instr_d;
            pc_q    <= pc_d;
            pc4_q   <= pc4_d;
        end
    end

    assign valid_o = valid_q;
    assign instr_o = instr_q;
    assign pc_o    = pc_q;
    assign pc4_o   = pc4_q;

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller. It owns the PC and the IDLE/RUN/HALTED/FAULT FSM,
// and it feeds fetched words into the output stage toward IF/ID.
module fetch_sequencer
    import fetch_sequencer_pkg::*;
#(
    parameter int                ADDR_W     = 32,
    parameter int                IMEM_DEPTH = 128,
    parameter logic [ADDR_W-1:0] RESET_PC   = '0
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              Start,
    input  logic              Redirect,
    input  logic [ADDR_W-1:0] RedirectTarget,
    output logic              Halted,
    output logic              Fault,
    fetch_sequencer_if.master bus
);

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              load;
    logic              flush;
    logic              target_illegal;
    logic              pc_at_last;

    // A target is unusable if it is misaligned or if it points past the end of memory.
    always_comb begin
        target_illegal = (RedirectTarget[1:0] != 2'b00) ||
                         ((RedirectTarget >> 2) >= ADDR_W'(IMEM_DEPTH));
        pc_at_last     = ((pc_q >> 2) == ADDR_W'(IMEM_DEPTH - 1));
    end

    // FSM and PC update. In RUN, a redirect outranks a fetch. A fetch from the
    // last word halts instead of advancing, so the PC saturates there.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        load    = 1'b0;
        flush   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (Start) begin
                    state_d = ST_RUN;
                    pc_d    = RESET_PC;
                end
            end
            ST_RUN: begin
                if (Redirect) begin
                    flush = 1'b1;
                    if (target_illegal) begin
                        state_d = ST_FAULT;
                    end else begin
                        pc_d = RedirectTarget;
                    end
                end else if (!bus.InstrValid || bus.InstrReady) begin
                    load = 1'b1;
                    if (pc_at_last) begin
                        state_d = ST_HALTED;
                    end else begin
                        pc_d = pc_q + ADDR_W'(PC_INC);
                    end
                end
            end
            ST_HALTED: begin
                if (Start) begin
                    state_d = ST_RUN;
                    pc_d    = RESET_PC;
                    flush   = 1'b1;
                end
            end
            ST_FAULT: begin
                flush = 1'b1;
            end
            default: begin
                state_d = ST_FAULT;
                flush   = 1'b1;
            end
        endcase
    end

    // State and PC registers, cleared immediately on reset.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= ST_IDLE;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    fetch_out_stage #(
        .ADDR_W (ADDR_W)
    ) u_out_stage (
        .clk      (Clk),
        .rst_n    (Reset_n),
        .flush    (flush),
        .load     (load),
        .ready    (bus.InstrReady),
        .instr_in (bus.ImemInstruction),
        .pc_in    (pc_q),
        .valid_o  (bus.InstrValid),
        .instr_o  (bus.Instruction),
        .pc_o     (bus.InstrPC),
        .pc4_o    (bus.PCPlus4)
    );

    assign bus.ImemAddress = pc_q;
    assign Halted          = (state_q == ST_HALTED);
    assign Fault           = (state_q == ST_FAULT);

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer. It runs directed scenarios and a random
// ready/redirect phase against a cycle-level behavioural model of the fetch rules.
module tb_fetch_sequencer;

   localparam int DEPTH = 128;

   logic        Clk;
   logic        Reset_n;
   logic        Start;
   logic        Redirect;
   logic [31:0] RedirectTarget;
   logic        Halted;
   logic        Fault;

   logic [31:0] mem [DEPTH];

   int checks = 0;
   int errors = 0;

   // Behavioural model: the mode is a name, and the fetch pointer is a byte address.
   string       mMode;
   int unsigned mPc;
   bit          mValid;
   int unsigned mInstr;
   int unsigned mInstrPc;

   fetch_sequencer_if #(.ADDR_W(32)) bus ();

   fetch_sequencer #(
      .ADDR_W     (32),
      .IMEM_DEPTH (DEPTH),
      .RESET_PC   (32'h0)
   ) dut (
      .Clk            (Clk),
      .Reset_n        (Reset_n),
      .Start          (Start),
      .Redirect       (Redirect),
      .RedirectTarget (RedirectTarget),
      .Halted         (Halted),
      .Fault          (Fault),
      .bus            (bus)
   );

   // Free-running clock
   initial begin
      Clk = 1'b0;
      forever #5 Clk = ~Clk;
   end

   // Combinational instruction memory
   always_comb begin
      bus.ImemInstruction = mem[bus.ImemAddress[8:2]];
   end

   // Hard time limit so that the run always terminates
   initial begin
      #2000000;
      $display("[TB] FAIL timeout: simulation did not finish in time");
      $fatal(1, "[TB] timeout");
   end

   task automatic checkValue(input string name, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s: observed %h expected %h", name, observed, expected);
      end
   endtask

   task automatic modelReset();
      mMode    = "IDLE";
      mPc      = 0;
      mValid   = 0;
      mInstr   = 0;
      mInstrPc = 0;
   endtask

   // One clock of fetch behaviour, evaluated from the values present before the edge
   task automatic modelStep(input bit start, input bit redirect, input int unsigned target, input bit ready);
      if (mMode == "IDLE") begin
         if (start) begin
            mMode = "RUN";
            mPc   = 0;
         end
         if (ready) mValid = 0;
      end else if (mMode == "RUN") begin
         if (redirect) begin
            mValid = 0;
            if ((target % 4) != 0 || (target / 4) >= DEPTH) mMode = "FAULT";
            else mPc = target;
         end else if (!mValid || ready) begin
            mValid   = 1;
            mInstr   = (mPc / 4) * 3;
            mInstrPc = mPc;
            if ((mPc / 4) == DEPTH - 1) mMode = "HALTED";
            else mPc = mPc + 4;
         end
      end else if (mMode == "HALTED") begin
         if (start) begin
            mMode  = "RUN";
            mPc    = 0;
            mValid = 0;
         end else if (ready) begin
            mValid = 0;
         end
      end else begin
         mValid = 0;
      end
   endtask

   task automatic checkOutput(input string tag);
      checkValue({tag, ".ImemAddress"}, bus.ImemAddress, mPc);
      checkValue({tag, ".InstrValid"}, {31'b0, bus.InstrValid}, {31'b0, mValid});
      if (mValid) begin
         checkValue({tag, ".Instruction"}, bus.Instruction, mInstr);
         checkValue({tag, ".InstrPC"}, bus.InstrPC, mInstrPc);
         checkValue({tag, ".PCPlus4"}, bus.PCPlus4, mInstrPc + 4);
      end
      checkValue({tag, ".Halted"}, {31'b0, Halted}, {31'b0, mMode == "HALTED"});
      checkValue({tag, ".Fault"}, {31'b0, Fault}, {31'b0, mMode == "FAULT"});
   endtask

   task automatic checkResetValues(input string tag);
      checkValue({tag, ".ImemAddress"}, bus.ImemAddress, 32'h0);
      checkValue({tag, ".InstrValid"}, {31'b0, bus.InstrValid}, 32'h0);
      checkValue({tag, ".Instruction"}, bus.Instruction, 32'h0);
      checkValue({tag, ".InstrPC"}, bus.InstrPC, 32'h0);
      checkValue({tag, ".PCPlus4"}, bus.PCPlus4, 32'h4);
      checkValue({tag, ".Halted"}, {31'b0, Halted}, 32'h0);
      checkValue({tag, ".Fault"}, {31'b0, Fault}, 32'h0);
   endtask

   // Drive one cycle of inputs, advance the clock and model, then compare just after the edge
   task automatic applyStimulus(input string tag, input bit start, input bit redirect,
                                input logic [31:0] target, input bit ready);
      Start          = start;
      Redirect       = redirect;
      RedirectTarget = target;
      bus.InstrReady = ready;
      modelStep(start, redirect, target, ready);
      @(posedge Clk);
      #1;
      checkOutput(tag);
   endtask

   task automatic doReset();
      Reset_n = 1'b0;
      modelReset();
      #1;
      checkResetValues("reset");
      @(negedge Clk);
      Reset_n = 1'b1;
      @(posedge Clk);
      #1;
   endtask

   initial begin
      for (int i = 0; i < DEPTH; i++) mem[i] = i * 3;
      Start          = 0;
      Redirect       = 0;
      RedirectTarget = 0;
      bus.InstrReady = 0;
      Reset_n        = 1;
      #3;
      doReset();

      // Start and stream the first words
      applyStimulus("start", 1, 0, 0, 1);
      applyStimulus("fetch0", 0, 0, 0, 1);
      checkValue("first.Instruction", bus.Instruction, 32'd0);
      applyStimulus("fetch1", 0, 0, 0, 1);
      checkValue("second.Instruction", bus.Instruction, 32'd3);
      applyStimulus("fetch2", 0, 0, 0, 1);
      checkValue("third.InstrPC", bus.InstrPC, 32'h8);

      // Stall with the PC=0x8 word held
      for (int i = 0; i < 3; i++) begin
         applyStimulus("stall", 0, 0, 0, 0);
         checkValue("stall.Instruction", bus.Instruction, 32'd6);
         checkValue("stall.ImemAddress", bus.ImemAddress, 32'hC);
      end
      applyStimulus("release", 0, 0, 0, 1);
      checkValue("release.Instruction", bus.Instruction, 32'd9);
      applyStimulus("fetch4", 0, 0, 0, 1);
      checkValue("fetch4.InstrPC", bus.InstrPC, 32'h10);

      // Redirect to 0x40 while the PC=0x10 word is being accepted
      applyStimulus("redirect", 0, 1, 32'h40, 1);
      checkValue("redirect.bubble", {31'b0, bus.InstrValid}, 32'h0);
      applyStimulus("target", 0, 0, 0, 1);
      checkValue("target.Instruction", bus.Instruction, 32'd48);
      checkValue("target.InstrPC", bus.InstrPC, 32'h40);

      // Random ready pattern with occasional legal redirects
      for (int i = 0; i < 300; i++) begin
         bit rdy;
         bit rd;
         rdy = ($urandom_range(0, 3) != 0);
         rd  = ($urandom_range(0, 15) == 0);
         applyStimulus("random", 0, rd, $urandom_range(0, DEPTH - 1) * 4, rdy);
      end

      // Run to the last word
      for (int i = 0; i < 400 && mMode != "HALTED"; i++) begin
         applyStimulus("toEnd", 0, 0, 0, 1);
      end
      checkValue("end.Halted", {31'b0, Halted}, 32'h1);
      checkValue("end.Instruction", bus.Instruction, 32'd381);
      checkValue("end.InstrPC", bus.InstrPC, 32'h1FC);
      applyStimulus("haltHold", 0, 1, 32'h40, 0);
      checkValue("haltHold.ImemAddress", bus.ImemAddress, 32'h1FC);
      applyStimulus("haltDrain", 0, 0, 0, 1);
      applyStimulus("haltIdle", 0, 0, 0, 1);
      applyStimulus("restart", 1, 1, 32'h80, 1);
      applyStimulus("restartFetch", 0, 0, 0, 1);
      checkValue("restart.Instruction", bus.Instruction, 32'd0);
      checkValue("restart.InstrPC", bus.InstrPC, 32'h0);
      applyStimulus("run", 0, 0, 0, 1);

      // Reset asserted between edges in the middle of a stall
      applyStimulus("preStall", 0, 0, 0, 0);
      applyStimulus("preStall", 0, 0, 0, 0);
      #2;
      Reset_n = 1'b0;
      modelReset();
      #1;
      checkResetValues("midStallReset");
      @(negedge Clk);
      Reset_n = 1'b1;
      @(posedge Clk);
      #1;

      // Misaligned redirect target
      applyStimulus("start2", 1, 0, 0, 1);
      applyStimulus("run2", 0, 0, 0, 1);
      applyStimulus("misaligned", 0, 1, 32'h42, 1);
      checkValue("misaligned.Fault", {31'b0, Fault}, 32'h1);
      applyStimulus("faultStart", 1, 0, 0, 1);
      applyStimulus("faultRedirect", 0, 1, 32'h40, 1);
      checkValue("faultStuck.InstrValid", {31'b0, bus.InstrValid}, 32'h0);
      doReset();

      // Out-of-range redirect target
      applyStimulus("start3", 1, 0, 0, 1);
      applyStimulus("run3", 0, 0, 0, 0);
      applyStimulus("outOfRange", 0, 1, 32'h200, 1);
      checkValue("outOfRange.Fault", {31'b0, Fault}, 32'h1);
      applyStimulus("faultHold", 1, 0, 0, 1);
      doReset();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Instruction-fetch controller for the MIPS datapath. It owns the program counter and drives the word-indexed, combinational-read instruction memory. It registers each fetched word with its PC into a single-entry output stage handshaken with the IF/ID register. It also handles start, branch/jump redirects with flush, end-of-program halt, and illegal-target faults.

## Interface
- `ADDR_W`, 32: PC and byte-address width.
- `IMEM_DEPTH`, 128: instruction memory words; index = `PC[8:2]` at default depth.
- `RESET_PC`, 32'h0: byte address of the first instruction.
- `Clk`  in  1: single clock, rising edge.
- `Reset_n`  in  1: asynchronous, active-low reset.
- `Start`  in  1: pulse; leaves IDLE or HALTED and begins fetching at `RESET_PC`.
- `ImemAddress`  out  ADDR_W: byte address presented to instruction memory; equals PC register.
- `ImemInstruction`  in  32: combinational read data for `ImemAddress`.
- `Redirect`  in  1: branch/jump taken this cycle.
- `RedirectTarget`  in  ADDR_W: new byte PC when `Redirect`=1.
- `InstrValid`  out  1: output stage holds a valid instruction.
- `InstrReady`  in  1: IF/ID accepts this cycle.
- `Instruction`  out  32: fetched word.
- `InstrPC`  out  ADDR_W: byte PC of `Instruction`.
- `PCPlus4`  out  ADDR_W: `InstrPC`+4.
- `Halted`  out  1: state is HALTED.
- `Fault`  out  1: state is FAULT (sticky).

## Operation
- States: IDLE, RUN, HALTED, FAULT.
- Reset values: state IDLE, PC=`RESET_PC`, `InstrValid`=0, `Instruction`/`InstrPC`=0, `PCPlus4`=4, `Halted`=0, `Fault`=0.
- IDLE: `Start` -> RUN with PC=`RESET_PC`. `Redirect` is ignored.
- RUN, load condition `load = !InstrValid || InstrReady`.
  - On `load`, the output stage takes {`ImemInstruction`, PC, PC+4}, `InstrValid`<=1, and PC<=PC+4.
  - When `!load`, PC and the output stage hold. This is a stall: no word is lost or duplicated.
- Redirect has priority over `load`.
  - `InstrValid`<=0, flushing the held word even if `InstrReady`=1 that cycle. That word counts as not consumed by the upstream contract.
  - PC<=`RedirectTarget`. No fetch occurs this cycle.
- Illegal target: `RedirectTarget[1:0]`!=0, or target word index >= `IMEM_DEPTH`. The block enters FAULT, `InstrValid`<=0, and PC keeps its old value.
- End of program: a load from the last word (index `IMEM_DEPTH`-1) enters HALTED. PC saturates at that word; no wrap to 0. The last instruction stays valid until consumed.
- HALTED: no fetch. The output stage still drains normally. `Redirect` is ignored. `Start` restarts as from IDLE and clears `InstrValid`.
- FAULT: no fetch, `InstrValid`=0, all inputs ignored. Only `Reset_n` exits.
- Simultaneous `Start` and `Redirect` in IDLE/HALTED: `Start` wins.
- PC arithmetic is modulo 2^`ADDR_W`. The range check prevents overflow in practice.

## Timing
- `Start` sampled at edge k: RUN after k. At edge k+1, word `RESET_PC` loads, so `InstrValid`=1 from k+1.
- Fetch latency is 1 cycle from PC to `InstrValid`. Throughput is 1 instruction/cycle while `InstrReady`=1.
- Redirect sampled at edge k: `InstrValid`=0 after k, target instruction valid after k+1. Cost is a 1-cycle bubble.
- All outputs are registered, except `ImemAddress`, which is a direct register output.
- `Reset_n` assertion clears state immediately, independent of `Clk`, including mid-stall and mid-redirect. Deassertion is synchronized externally.

## Structure
- A shared package holds the state encoding (2-bit enum: IDLE, RUN, HALTED, FAULT) and a `NOP_WORD` = 32'h0 constant for the flushed `Instruction` value.
- `PC_INC` = 4 lives in the same package.
- One natural sub-module: `fetch_out_stage`, the valid/ready output register with flush. The PC/FSM stays in the top.

## Test plan
- Memory initialised `memory[i]=i*3`, reset, `Start`, `InstrReady`=1 -> `InstrValid` from cycle 2, `Instruction` sequence 0,3,6,9 with `InstrPC` 0x0,0x4,0x8,0xC.
- After the PC=0x8 word is valid, hold `InstrReady`=0 for 3 cycles -> `Instruction`=6 and `InstrPC`=0x8 stable, `ImemAddress`=0xC. On release, the next word is 9.
- `Redirect` with target 0x40 while PC=0x10 is valid and `InstrReady`=1 -> next cycle `InstrValid`=0. Following cycle `Instruction`=48, `InstrPC`=0x40. No word 12 delivered.
- `Redirect` with target 0x42, then separately target 0x200 at depth 128 -> `Fault`=1, `InstrValid`=0 permanently. `Start` has no effect, and `Reset_n` low clears it.
- Run to index 127 -> `Instruction`=381, `InstrPC`=0x1FC, then `Halted`=1 with no further fetch. `Start` -> word 0 is fetched again.
- Assert `Reset_n`=0 mid-stall between edges -> outputs go to their reset values immediately.
